// File: rtl/yfilter_mc.sv
// rtl/yfilter_mc.sv - multi-channel vertical binomial low-pass filter, 3-stage valid/ready pipeline
module yfilter_mc #(
  parameter int PB   = 8,
  parameter int NCH  = 3,
  parameter int TAPS = 3,
  parameter int NORM = 0,
  localparam int S   = (TAPS == 5) ? 4 : 2,
  localparam int OW  = (NORM != 0) ? PB : PB + S
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [NCH*TAPS*PB-1:0]   i_pixelset,
  input  logic [1:0]               i_top_dist,
  input  logic [1:0]               i_bot_dist,
  input  logic                     i_border,
  input  logic                     i_col1,
  input  logic                     i_colN,
  input  logic                     i_rowM,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [NCH*OW-1:0]        o_pixel,
  output logic                     o_col1,
  output logic                     o_colN,
  output logic                     o_rowM
);

  localparam int C  = TAPS / 2;
  localparam int SW = PB + S;

  if (!(TAPS == 3 || TAPS == 5)) begin : g_bad_taps
    $error("yfilter_mc: TAPS must be 3 or 5");
  end
  if (NCH < 1 || NCH > 4) begin : g_bad_nch
    $error("yfilter_mc: NCH must be 1..4");
  end

  logic en;
  assign en      = i_ready | ~o_valid;
  assign o_ready = en;

  // S1: raw capture of the beat and its edge information
  logic                   v1;
  logic [NCH*TAPS*PB-1:0] px1;
  logic [1:0]             top1, bot1;
  logic                   brd1;
  logic [2:0]             fl1;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1   <= 1'b0;
      px1  <= '0;
      top1 <= '0;
      bot1 <= '0;
      brd1 <= 1'b0;
      fl1  <= '0;
    end else if (en) begin
      v1   <= i_valid;
      px1  <= i_pixelset;
      top1 <= i_top_dist;
      bot1 <= i_bot_dist;
      brd1 <= i_border;
      fl1  <= {i_col1, i_colN, i_rowM};
    end
  end

  // Each tap decides independently, so short images mask on both sides at once
  logic [PB-1:0] tap1 [NCH][TAPS];

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      for (int k = 0; k < TAPS; k++) begin
        tap1[c][k] = px1[(c*TAPS+k)*PB +: PB];
        if (k + int'(top1) < C)
          tap1[c][k] = brd1 ? px1[(c*TAPS+C-int'(top1))*PB +: PB] : '0;
        else if (k > C + int'(bot1))
          tap1[c][k] = brd1 ? px1[(c*TAPS+C+int'(bot1))*PB +: PB] : '0;
      end
    end
  end

  logic [SW-1:0] upc [NCH];
  logic [SW-1:0] loc [NCH];

  if (TAPS == 3) begin : g_w3
    always_comb begin
      for (int c = 0; c < NCH; c++) begin
        upc[c] = SW'(tap1[c][0]);
        loc[c] = (SW'(tap1[c][1]) << 1) + SW'(tap1[c][2]);
      end
    end
  end else begin : g_w5
    always_comb begin
      for (int c = 0; c < NCH; c++) begin
        upc[c] = SW'(tap1[c][0]) + (SW'(tap1[c][1]) << 2);
        loc[c] = (SW'(tap1[c][2]) << 2) + (SW'(tap1[c][2]) << 1)
               + (SW'(tap1[c][3]) << 2) + SW'(tap1[c][4]);
      end
    end
  end

  // S2: partial sums
  logic          v2;
  logic [2:0]    fl2;
  logic [SW-1:0] up2 [NCH];
  logic [SW-1:0] lo2 [NCH];

  always_ff @(posedge clk) begin
    if (rst) begin
      v2  <= 1'b0;
      fl2 <= '0;
      for (int c = 0; c < NCH; c++) begin
        up2[c] <= '0;
        lo2[c] <= '0;
      end
    end else if (en) begin
      v2  <= v1;
      fl2 <= fl1;
      for (int c = 0; c < NCH; c++) begin
        up2[c] <= upc[c];
        lo2[c] <= loc[c];
      end
    end
  end

  logic [NCH*OW-1:0] pixc;

  // Full-weight maximum plus the rounding constant still fits in SW bits
  if (NORM != 0) begin : g_norm
    always_comb begin
      logic [SW-1:0] rnd;
      pixc = '0;
      rnd  = '0;
      for (int c = 0; c < NCH; c++) begin
        rnd = up2[c] + lo2[c] + SW'(1 << (S-1));
        pixc[c*OW +: OW] = rnd[SW-1:S];
      end
    end
  end else begin : g_raw
    always_comb begin
      pixc = '0;
      for (int c = 0; c < NCH; c++)
        pixc[c*OW +: OW] = up2[c] + lo2[c];
    end
  end

  // S3: output register
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_pixel <= '0;
      o_col1  <= 1'b0;
      o_colN  <= 1'b0;
      o_rowM  <= 1'b0;
    end else if (en) begin
      o_valid <= v2;
      o_pixel <= pixc;
      {o_col1, o_colN, o_rowM} <= fl2;
    end
  end

endmodule

// File: tb/tb_yfilter_mc.sv
// tb/tb_yfilter_mc.sv - scoreboard bench for yfilter_mc (3-tap raw, 5-tap raw, 5-tap rounded)
module tb_yfilter_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, i_valid, i_ready, i_border, i_col1, i_colN, i_rowM;
  logic [1:0]  top, bot;
  logic [71:0] ps3;
  logic [119:0] ps5;

  logic        o_ready3, o_valid3, f1_3, fn_3, fm_3;
  logic [29:0] o_pixel3;
  logic        o_ready5, o_valid5, f1_5, fn_5, fm_5;
  logic [35:0] o_pixel5;
  logic        o_readyn, o_validn, f1_n, fn_n, fm_n;
  logic [23:0] o_pixeln;

  yfilter_mc #(.PB(8), .NCH(3), .TAPS(3), .NORM(0)) dut3 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready3), .i_pixelset(ps3),
    .i_top_dist(top), .i_bot_dist(bot), .i_border(i_border),
    .i_col1(i_col1), .i_colN(i_colN), .i_rowM(i_rowM),
    .o_valid(o_valid3), .i_ready(i_ready), .o_pixel(o_pixel3),
    .o_col1(f1_3), .o_colN(fn_3), .o_rowM(fm_3));

  yfilter_mc #(.PB(8), .NCH(3), .TAPS(5), .NORM(0)) dut5 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready5), .i_pixelset(ps5),
    .i_top_dist(top), .i_bot_dist(bot), .i_border(i_border),
    .i_col1(i_col1), .i_colN(i_colN), .i_rowM(i_rowM),
    .o_valid(o_valid5), .i_ready(i_ready), .o_pixel(o_pixel5),
    .o_col1(f1_5), .o_colN(fn_5), .o_rowM(fm_5));

  yfilter_mc #(.PB(8), .NCH(3), .TAPS(5), .NORM(1)) dutn (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_readyn), .i_pixelset(ps5),
    .i_top_dist(top), .i_bot_dist(bot), .i_border(i_border),
    .i_col1(i_col1), .i_colN(i_colN), .i_rowM(i_rowM),
    .o_valid(o_validn), .i_ready(i_ready), .o_pixel(o_pixeln),
    .o_col1(f1_n), .o_colN(fn_n), .o_rowM(fm_n));

  typedef struct {
    logic [29:0] p3;
    logic [35:0] p5;
    logic [23:0] pn;
    logic [2:0]  fl;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  tp [3][5];
  int          n_assert = 0;
  int          n_fail = 0;
  bit          acc, stalled;
  logic [29:0] held_px;
  logic [2:0]  held_fl;
  int          stall_left = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int weight(input int t, input int k);
    if (t == 3) return (k == 1) ? 2 : 1;
    if (k == 0 || k == 4) return 1;
    return (k == 2) ? 6 : 4;
  endfunction

  function automatic int model(input int t, input int c, input bit norm);
    int cc, s, sum, idx;
    cc = t / 2; s = (t == 3) ? 2 : 4; sum = 0;
    for (int k = 0; k < t; k++) begin
      idx = k;
      if (k < cc - int'(top)) idx = i_border ? cc - int'(top) : -1;
      else if (k > cc + int'(bot)) idx = i_border ? cc + int'(bot) : -1;
      if (idx >= 0) sum += weight(t, k) * int'(tp[c][idx]);
    end
    return norm ? (sum + (1 << (s-1))) >> s : sum;
  endfunction

  task automatic load_taps();
    for (int c = 0; c < 3; c++)
      for (int k = 0; k < 5; k++) begin
        ps5[(c*5+k)*8 +: 8] = tp[c][k];
        if (k < 3) ps3[(c*3+k)*8 +: 8] = tp[c][k];
      end
  endtask

  task automatic fill(input int c, input int a, input int b, input int m, input int d, input int e);
    tp[c][0] = 8'(a); tp[c][1] = 8'(b); tp[c][2] = 8'(m); tp[c][3] = 8'(d); tp[c][4] = 8'(e);
  endtask

  task automatic rand_beat();
    for (int c = 0; c < 3; c++)
      for (int k = 0; k < 5; k++) tp[c][k] = 8'($urandom_range(0, 255));
    top = 2'($urandom_range(0, 2));
    bot = 2'($urandom_range(0, 2));
    i_border = 1'($urandom_range(0, 1));
  endtask

  task automatic step(input bit v, input bit rdy);
    exp_t e;
    i_valid = v; i_ready = rdy;
    load_taps();
    #1;
    check("o_ready", o_ready3, rdy || !o_valid3);
    if (o_valid3 && !rdy) begin
      if (stalled) begin
        check("hold_pixel", o_pixel3, held_px);
        check("hold_flags", {f1_3, fn_3, fm_3}, held_fl);
      end
      stalled = 1; held_px = o_pixel3; held_fl = {f1_3, fn_3, fm_3};
    end else stalled = 0;
    if (o_valid3 && rdy) begin
      if (sb.size() == 0) check("stale_valid", o_valid3, 0);
      else begin
        e = sb.pop_front();
        check("pixel_t3", o_pixel3, e.p3);
        check("pixel_t5", o_pixel5, e.p5);
        check("pixel_t5n", o_pixeln, e.pn);
        check("flags", {f1_3, fn_3, fm_3}, e.fl);
      end
    end
    acc = v && o_ready3;
    if (acc) begin
      for (int c = 0; c < 3; c++) begin
        e.p3[c*10 +: 10] = 10'(model(3, c, 0));
        e.p5[c*12 +: 12] = 12'(model(5, c, 0));
        e.pn[c*8 +: 8]   = 8'(model(5, c, 1));
      end
      e.fl = {i_col1, i_colN, i_rowM};
      sb.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic send(input bit rnd_rdy);
    int guard;
    bit rdy;
    guard = 0; acc = 0;
    while (!acc && guard < 50) begin
      if (stall_left > 0) begin rdy = 0; stall_left--; end
      else rdy = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      step(1, rdy);
      guard++;
    end
    if (!acc) check("accept_timeout", acc, 1);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() > 0 && guard < 60) begin step(0, 1); guard++; end
    check("drain_empty", sb.size(), 0);
    repeat (3) step(0, 1);
  endtask

  initial begin
    rst = 1; i_valid = 0; i_ready = 0; top = 2; bot = 2; i_border = 0;
    i_col1 = 0; i_colN = 0; i_rowM = 0; stalled = 0;
    for (int c = 0; c < 3; c++) fill(c, 0, 0, 0, 0, 0);
    load_taps();
    repeat (2) @(posedge clk);
    #1;
    check("rst_o_valid", o_valid3, 0);
    check("rst_o_pixel", o_pixel3, 0);
    check("rst_flags", {f1_3, fn_3, fm_3}, 0);
    check("rst_o_ready", o_ready3, 1);
    rst = 0;

    // interior beat with latency probe
    fill(0, 10, 20, 30, 40, 50); fill(1, 1, 2, 3, 4, 5); fill(2, 255, 255, 255, 255, 255);
    step(1, 1);
    check("lat_edge1", o_valid3, 0);
    step(0, 1);
    check("lat_edge2", o_valid3, 0);
    step(0, 1);
    check("lat_edge3", o_valid3, 1);
    check("interior_80", o_pixel3[9:0], 80);
    drain();

    // edge handling
    fill(0, 99, 20, 30, 40, 50);
    top = 0; i_border = 0; step(1, 1);
    i_border = 1; step(1, 1);
    fill(0, 10, 20, 99, 40, 50);
    top = 2; bot = 0; i_border = 0; step(1, 1);
    i_border = 1; step(1, 1);
    for (int c = 0; c < 3; c++) fill(c, 255, 255, 255, 255, 255);
    bot = 2; i_border = 0; step(1, 1);
    top = 1; step(1, 1);
    top = 0; bot = 0; step(1, 1);
    i_border = 1; step(1, 1);
    drain();

    // back-to-back with a 4-cycle downstream stall and sideband markers
    for (int b = 0; b < 10; b++) begin
      rand_beat();
      i_col1 = (b == 0); i_colN = (b == 7); i_rowM = (b == 7);
      if (b == 5) stall_left = 4;
      send(0);
    end
    i_col1 = 0; i_colN = 0; i_rowM = 0;
    drain();

    // same pattern under random downstream readiness
    for (int b = 0; b < 24; b++) begin
      rand_beat();
      i_col1 = (b == 0); i_colN = (b == 7); i_rowM = (b == 7);
      send(1);
      if ($urandom_range(0, 2) == 0) step(0, 1'($urandom_range(0, 1)));
    end
    i_col1 = 0; i_colN = 0; i_rowM = 0;
    drain();

    // reset with three beats in flight
    repeat (3) begin rand_beat(); step(1, 1); end
    rst = 1; i_valid = 0; i_ready = 0;
    @(posedge clk); #1;
    rst = 0;
    check("midrst_o_valid", o_valid3, 0);
    check("midrst_o_pixel", o_pixel3, 0);
    sb.delete(); stalled = 0;
    repeat (5) step(0, 1);
    fill(0, 10, 20, 30, 40, 50); top = 2; bot = 2; i_border = 0;
    step(1, 1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/yfilter_mc.md
# yfilter_mc

Multi-channel, parametrised vertical binomial low-pass filter with valid/ready flow control. It sits after the row-buffer BRAM read stage and before the horizontal filter in the low-pass image pipeline. Each accepted beat carries a column of TAPS vertically adjacent pixels per channel and returns one filtered pixel per channel. Image top and bottom edges are handled with a selectable zero or replicate border.

## Interface
- PB, 8: pixel width per channel.
- NCH, 3: channel count (1..4).
- TAPS, 3: kernel length; 3 gives weights 1-2-1 (S=2), 5 gives weights 1-4-6-4-1 (S=4). Other values are illegal and are rejected by an elaboration-time check.
- NORM, 0: 0 gives raw sums with OW = PB+S; 1 gives rounded output with OW = PB.

- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- i_valid  in  1  input beat present.
- o_ready  out  1  block accepts a beat this cycle.
- i_pixelset  in  NCH*TAPS*PB  channel c, tap k at bits [(c*TAPS+k)*PB +: PB]; tap 0 is the topmost row and tap TAPS/2 is the centre.
- i_top_dist  in  2  rows between the centre and the image top; saturates at 2.
- i_bot_dist  in  2  rows between the centre and the image bottom; saturates at 2.
- i_border  in  1  0 = zero border, 1 = replicate border.
- i_col1, i_colN, i_rowM  in  1 each  first-column, last-column and last-row sideband flags.
- o_valid  out  1  output beat present.
- i_ready  in  1  downstream accepts the output beat.
- o_pixel  out  NCH*OW  channel c at bits [c*OW +: OW].
- o_col1, o_colN, o_rowM  out  1 each  sideband flags, aligned with o_pixel.

## Operation
- Global stage enable: en = i_ready | ~o_valid. o_ready = en.
- A beat is accepted when i_valid & o_ready. The whole pipeline freezes when en=0. Bubbles are not collapsed.
- Tap k is out-of-image if k < TAPS/2 − i_top_dist, or if k > TAPS/2 + i_bot_dist.
- Each tap is evaluated independently, so images shorter than TAPS rows are legal.
- Zero border: out-of-image taps contribute 0. Sums at the edges are therefore below full weight.
- Replicate border: an out-of-image tap above the image takes tap TAPS/2 − i_top_dist; one below the image takes tap TAPS/2 + i_bot_dist.
- Pipeline stage S1: register the taps, sideband flags and valid, then apply masking or replication.
- Pipeline stage S2: per-channel weighted partial sums, shifts only, no multipliers. Upper partial = taps above the centre; lower partial = centre plus the taps below.
- Pipeline stage S3: final sum per channel. If NORM=1, output (sum + 2^(S−1)) >> S.
- Width rule: the raw sum is at most (2^PB − 1)·2^S, so it fits in PB+S bits with no saturation. The NORM result fits in PB bits.
- Channels are computed in parallel and never interact.

## Timing
- Latency: 3 enabled cycles from accept to o_valid. Throughput is 1 beat per cycle when i_ready stays high.
- Reset: all stage valids, o_valid, o_pixel, o_col1, o_colN and o_rowM are 0 on the cycle after rst is sampled high. o_ready is 1 during and after reset.
- Reset mid-stream discards all in-flight beats; none are emitted afterwards.
- Stall: while o_valid=1 and i_ready=0, o_pixel and the sideband outputs hold bit-stable and o_ready=0. An input presented in that cycle is not accepted.
- Simultaneous output and input handshake in one cycle: the output is consumed, the input is accepted, and the pipeline shifts once.
- Sideband flags experience exactly the same latency and stalls as the pixel data.

## Test plan
- PB=8, TAPS=3, NORM=0, interior beat, one channel with taps 10, 20, 30 → o_pixel = 80 after 3 cycles. Same beat with NORM=1 → 20.
- Top row (i_top_dist=0), taps x, 20, 30: i_border=0 → 70; i_border=1 → 90. Bottom row (i_bot_dist=0), taps 10, 20, x, i_border=0 → 50.
- TAPS=5, NCH=3, all taps 255, interior → every channel outputs 4080 (12 bits). With NORM=1 → 255. With i_top_dist=1 and zero border → 3825.
- 10 back-to-back beats, i_ready held low for 4 cycles mid-stream → no beat lost or duplicated, order preserved, outputs stable while stalled, o_ready low exactly while stalled with o_valid=1.
- Sideband: i_col1 set on beat 0, i_colN on beat 7, i_rowM on beat 7 → flags appear on the same output beats, including under random i_ready.
- rst asserted for 1 cycle with 3 beats in flight → o_valid=0 and o_pixel=0 next cycle, no stale beat afterwards, and normal operation on the next accepted beat.
